// File: rtl/lock_pkg.sv
// Shared types and width helpers for the digital lock controller.
package lock_pkg;

   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      ENTRY    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } lock_state_t;

   localparam int DEF_CODE_W         = 4;
   localparam int DEF_MAX_FAILS      = 3;
   localparam int DEF_UNLOCK_CYCLES  = 16;
   localparam int DEF_LOCKOUT_CYCLES = 64;
   localparam int DEF_TIMEOUT_CYCLES = 32;

   // Bits needed to hold the values 0..n-1, never less than one bit.
   function automatic int bits_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   localparam int TIMER_W = bits_for(max3(DEF_UNLOCK_CYCLES, DEF_LOCKOUT_CYCLES,
                                          DEF_TIMEOUT_CYCLES));
   localparam int FAIL_W  = bits_for(DEF_MAX_FAILS + 1);

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the entry timeout, unlock hold and lockout phases.
// The load value is the cycle count minus one, so expire rises on the last cycle of the interval.
module lock_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expire
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Digital lock sequencer: serial code entry, compare, fail counting, lockout and
// timed unlock with code reprogramming while open.
module lock_controller
   import lock_pkg::*;
#(
   parameter int                CODE_W         = DEF_CODE_W,
   parameter logic [CODE_W-1:0] DEFAULT_CODE   = 4'b1011,
   parameter int                MAX_FAILS      = DEF_MAX_FAILS,
   parameter int                UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
   parameter int                LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
   parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                bit_valid,
   input  logic                                bit_in,
   input  logic                                clear,
   input  logic                                prog_valid,
   input  logic [CODE_W-1:0]                   prog_code,
   output logic                                unlocked,
   output logic                                alarm,
   output logic                                match,
   output logic                                mismatch,
   output logic [bits_for(MAX_FAILS+1)-1:0]    fail_cnt
);

   localparam int TMR_W  = bits_for(max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES));
   localparam int FCNT_W = bits_for(MAX_FAILS + 1);
   localparam int BCNT_W = bits_for(CODE_W);

   localparam logic [TMR_W-1:0]  UNLOCK_LD  = TMR_W'(UNLOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOCKOUT_LD = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(CODE_W - 1);
   localparam logic [FCNT_W-1:0] FAIL_LIMIT = FCNT_W'(MAX_FAILS);

   lock_state_t        state_q, state_d;
   logic [CODE_W-1:0]  shreg;
   logic [CODE_W-1:0]  code_reg;
   logic [CODE_W-1:0]  entered;
   logic [BCNT_W-1:0]  bit_cnt;
   logic [FCNT_W-1:0]  fails_next;
   logic               last_bit;
   logic               resolve;
   logic               shift_en;
   logic               set_match;
   logic               set_mismatch;
   logic               fails_clr;
   logic               prog_we;
   logic               timer_load;
   logic [TMR_W-1:0]   timer_val;
   logic               timer_expire;

   lock_timer #(
      .W (TMR_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .value  (timer_val),
      .expire (timer_expire)
   );

   // bit_cnt is zero outside ENTRY, so a one-bit code completes straight from LOCKED.
   assign entered    = CODE_W'({shreg, bit_in});
   assign last_bit   = (bit_cnt == LAST_BIT);
   assign fails_next = fail_cnt + 1'b1;
   assign prog_we    = (state_q == UNLOCKED) && prog_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      resolve      = 1'b0;
      shift_en     = 1'b0;
      set_match    = 1'b0;
      set_mismatch = 1'b0;
      fails_clr    = 1'b0;
      timer_load   = 1'b0;
      timer_val    = '0;

      case (state_q)
         LOCKED: begin
            if (bit_valid) begin
               if (last_bit) begin
                  resolve = 1'b1;
               end else begin
                  state_d    = ENTRY;
                  shift_en   = 1'b1;
                  timer_load = 1'b1;
                  timer_val  = TIMEOUT_LD;
               end
            end
         end
         ENTRY: begin
            if (clear) begin
               state_d = LOCKED;
            end else if (bit_valid) begin
               if (last_bit) begin
                  resolve = 1'b1;
               end else begin
                  shift_en   = 1'b1;
                  timer_load = 1'b1;
                  timer_val  = TIMEOUT_LD;
               end
            end else if (timer_expire) begin
               state_d = LOCKED;
            end
         end
         UNLOCKED: begin
            if (clear) begin
               state_d = LOCKED;
            end else if (prog_valid) begin
               timer_load = 1'b1;
               timer_val  = UNLOCK_LD;
            end else if (timer_expire) begin
               state_d = LOCKED;
            end
         end
         LOCKOUT: begin
            if (timer_expire) begin
               state_d   = LOCKED;
               fails_clr = 1'b1;
            end
         end
         default: begin
            state_d = LOCKED;
         end
      endcase

      // A completed entry is judged against the full code including the bit arriving now.
      if (resolve) begin
         if (entered == code_reg) begin
            state_d    = UNLOCKED;
            set_match  = 1'b1;
            fails_clr  = 1'b1;
            timer_load = 1'b1;
            timer_val  = UNLOCK_LD;
         end else begin
            set_mismatch = 1'b1;
            if (fails_next == FAIL_LIMIT) begin
               state_d    = LOCKOUT;
               timer_load = 1'b1;
               timer_val  = LOCKOUT_LD;
            end else begin
               state_d = LOCKED;
            end
         end
      end
   end

   always_comb begin
      unlocked = (state_q == UNLOCKED);
      alarm    = (state_q == LOCKOUT);
   end

   // Partial codes are wiped whenever the FSM leaves ENTRY for any reason.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (shift_en) begin
         shreg   <= entered;
         bit_cnt <= bit_cnt + 1'b1;
      end else if (state_d != ENTRY) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fail_cnt <= '0;
         match    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         match    <= set_match;
         mismatch <= set_mismatch;
         if (fails_clr) begin
            fail_cnt <= '0;
         end else if (set_mismatch) begin
            fail_cnt <= fails_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         code_reg <= DEFAULT_CODE;
      end else if (prog_we) begin
         code_reg <= prog_code;
      end
   end

endmodule
